pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline (IF->OF->ALU->DM->WB).

---
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF->OF->ALU->DM->WB pipeline.
// Optional performance counters are built in when PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int DM_WAIT_W  = 4,
    parameter int DM_TIMEOUT = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        is_Ld_ALU,
    input  logic [4:0]  rd_ALU,
    input  logic [4:0]  rs1_OF,
    input  logic [4:0]  rs2_OF,
    input  logic        use_rs1_OF,
    input  logic        use_rs2_OF,
    input  logic        branch_taken_ALU,
    input  logic        is_Ld_DM,
    input  logic        is_St_DM,
    input  logic        dm_ack,
    output logic        dm_req,
    output logic        stall_pc,
    output logic        stall_IFOF,
    output logic        stall_OFALU,
    output logic        stall_ALUDM,
    output logic        flush_IFOF,
    output logic        bubble_OFALU,
    output logic        bubble_DMWB,
    output logic        dm_err,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DM_WAIT = 2'd1,
        ERR     = 2'd2
    } state_t;

    localparam logic [DM_WAIT_W-1:0] TMO = DM_WAIT_W'(DM_TIMEOUT);
    localparam logic [DM_WAIT_W-1:0] ONE = DM_WAIT_W'(1);

    state_t               state, state_nxt;
    logic [DM_WAIT_W-1:0] wcnt, wcnt_nxt;
    logic                 mem_dm;
    logic                 dm_hold;
    logic                 load_use;

    assign mem_dm  = is_Ld_DM | is_St_DM;
    assign dm_hold = (state == ERR) | (mem_dm & ~dm_ack);
    assign load_use = is_Ld_ALU &
                      ((use_rs1_OF & (rs1_OF == rd_ALU)) |
                       (use_rs2_OF & (rs2_OF == rd_ALU)));

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Next-state: track an outstanding DM access and its timeout
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        unique case (state)
            RUN: begin
                if (mem_dm & ~dm_ack) begin
                    state_nxt = DM_WAIT;
                    wcnt_nxt  = ONE;
                end
            end
            DM_WAIT: begin
                if (dm_ack) begin
                    state_nxt = RUN;
                    wcnt_nxt  = '0;
                end else if (wcnt == TMO) begin
                    state_nxt = ERR;
                end else begin
                    wcnt_nxt = wcnt + ONE;
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt = RUN;
                wcnt_nxt  = '0;
            end
        endcase
    end

    // Outputs: Mealy priority decode, forced low while in reset
    always_comb begin
        dm_req       = 1'b0;
        stall_pc     = 1'b0;
        stall_IFOF   = 1'b0;
        stall_OFALU  = 1'b0;
        stall_ALUDM  = 1'b0;
        flush_IFOF   = 1'b0;
        bubble_OFALU = 1'b0;
        bubble_DMWB  = 1'b0;
        dm_err       = 1'b0;
        if (rst_n) begin
            dm_req = mem_dm & (state != ERR);
            dm_err = (state == ERR);
            if (dm_hold) begin
                stall_pc    = 1'b1;
                stall_IFOF  = 1'b1;
                stall_OFALU = 1'b1;
                stall_ALUDM = 1'b1;
                bubble_DMWB = 1'b1;
            end else if (branch_taken_ALU) begin
                flush_IFOF   = 1'b1;
                bubble_OFALU = 1'b1;
            end else if (load_use) begin
                stall_pc     = 1'b1;
                stall_IFOF   = 1'b1;
                bubble_OFALU = 1'b1;
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Count stalled and flushed cycles; both wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_pc)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_IFOF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then constrained random
// traffic, checked against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int TMO = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        is_Ld_ALU = 1'b0;
    logic [4:0]  rd_ALU = '0;
    logic [4:0]  rs1_OF = '0;
    logic [4:0]  rs2_OF = '0;
    logic        use_rs1_OF = 1'b0;
    logic        use_rs2_OF = 1'b0;
    logic        branch_taken_ALU = 1'b0;
    logic        is_Ld_DM = 1'b0;
    logic        is_St_DM = 1'b0;
    logic        dm_ack = 1'b0;
    logic        dm_req;
    logic        stall_pc, stall_IFOF, stall_OFALU, stall_ALUDM;
    logic        flush_IFOF, bubble_OFALU, bubble_DMWB, dm_err;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .is_Ld_ALU(is_Ld_ALU), .rd_ALU(rd_ALU),
        .rs1_OF(rs1_OF), .rs2_OF(rs2_OF),
        .use_rs1_OF(use_rs1_OF), .use_rs2_OF(use_rs2_OF),
        .branch_taken_ALU(branch_taken_ALU),
        .is_Ld_DM(is_Ld_DM), .is_St_DM(is_St_DM),
        .dm_ack(dm_ack), .dm_req(dm_req),
        .stall_pc(stall_pc), .stall_IFOF(stall_IFOF),
        .stall_OFALU(stall_OFALU), .stall_ALUDM(stall_ALUDM),
        .flush_IFOF(flush_IFOF), .bubble_OFALU(bubble_OFALU),
        .bubble_DMWB(bubble_DMWB), .dm_err(dm_err),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    // Reference model state: consecutive unacked memory cycles and error flag
    int          m_wait = 0;
    bit          m_err = 1'b0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;
    logic [8:0]  last_obs;

    // Bit order: req, stall_pc, IFOF, OFALU, ALUDM, flush, bub_OFALU, bub_DMWB, err
    function automatic logic [8:0] obs();
        return {dm_req, stall_pc, stall_IFOF, stall_OFALU, stall_ALUDM,
                flush_IFOF, bubble_OFALU, bubble_DMWB, dm_err};
    endfunction

    function automatic logic [8:0] model_out();
        logic [8:0] e;
        logic mem, hold, lu;
        e = '0;
        if (rst_n) begin
            mem  = is_Ld_DM | is_St_DM;
            hold = m_err | (mem & ~dm_ack);
            lu   = is_Ld_ALU &&
                   ((use_rs1_OF && rs1_OF == rd_ALU) ||
                    (use_rs2_OF && rs2_OF == rd_ALU));
            e[8] = mem & ~m_err;
            e[0] = m_err;
            if (hold)
                e[7:4] = 4'hF;
            if (hold)
                e[1] = 1'b1;
            else if (branch_taken_ALU)
                e[3:2] = 2'b11;
            else if (lu)
                e[7:6] = 2'b11;
            if (!hold && !branch_taken_ALU && lu)
                e[2] = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // One clock: compare at negedge, then advance model at posedge
    task automatic cyc(input string tag);
        logic [8:0] e;
        logic mem;
        @(negedge clk);
        e = model_out();
        last_obs = obs();
        chk(tag, {55'd0, last_obs}, {55'd0, e});
        chk({tag, "_perf"}, {perf_stall_cnt, perf_flush_cnt},
            {m_stall, m_flush});
        @(posedge clk);
        mem = is_Ld_DM | is_St_DM;
        if (rst_n) begin
`ifdef PERF_CNT_EN
            m_stall = m_stall + 32'(e[7]);
            m_flush = m_flush + 32'(e[3]);
`endif
            if (!m_err) begin
                if (mem && !dm_ack) begin
                    m_wait++;
                    if (m_wait > TMO)
                        m_err = 1'b1;
                end else begin
                    m_wait = 0;
                end
            end
        end
        #1;
    endtask

    task automatic clr();
        is_Ld_ALU = 0; rd_ALU = 0; rs1_OF = 0; rs2_OF = 0;
        use_rs1_OF = 0; use_rs2_OF = 0; branch_taken_ALU = 0;
        is_Ld_DM = 0; is_St_DM = 0; dm_ack = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_wait = 0; m_err = 1'b0; m_stall = '0; m_flush = '0;
        is_Ld_DM = 1; branch_taken_ALU = 1;
        cyc("in_reset");
        clr();
        cyc("in_reset2");
        rst_n = 1'b1;
    endtask

    initial begin
        int  req_n, ald_n, dly;
        bit  busy;
        #1;
        do_reset();
        cyc("idle0");
        chk("idle_zero", {55'd0, last_obs}, 64'd0);

        // Load-use on rs1
        is_Ld_ALU = 1; rd_ALU = 5; use_rs1_OF = 1; rs1_OF = 5;
        cyc("lu_hit");
        chk("lu_hit_bits", {55'd0, last_obs}, 64'h0C4);
        clr();
        cyc("lu_after");
        chk("lu_after_zero", {55'd0, last_obs}, 64'd0);
        is_Ld_ALU = 1; rd_ALU = 5; use_rs1_OF = 1; rs1_OF = 6;
        cyc("lu_miss");
        chk("lu_miss_zero", {55'd0, last_obs}, 64'd0);
        clr();

        // Load with 3 wait cycles then ack
        req_n = 0; ald_n = 0;
        is_Ld_DM = 1;
        for (int i = 0; i < 4; i++) begin
            dm_ack = (i == 3);
            cyc("dm_wait3");
            req_n += int'(last_obs[8]);
            ald_n += int'(last_obs[4]);
        end
        clr();
        cyc("dm_release");
        chk("dm_req_cycles", 64'(req_n), 64'd4);
        chk("dm_stall_cycles", 64'(ald_n), 64'd3);

        // Zero-wait store
        is_St_DM = 1; dm_ack = 1;
        cyc("zero_wait");
        chk("zero_wait_bits", {55'd0, last_obs}, 64'h100);
        clr();

        // Branch beats load-use; DM hold beats branch
        is_Ld_ALU = 1; rd_ALU = 9; use_rs2_OF = 1; rs2_OF = 9;
        branch_taken_ALU = 1;
        cyc("br_lu");
        chk("br_lu_bits", {55'd0, last_obs}, 64'h00C);
        is_Ld_DM = 1;
        cyc("br_dm");
        chk("br_dm_bits", {55'd0, last_obs}, 64'h1F2);
        clr();
        is_Ld_DM = 1; dm_ack = 1;
        cyc("br_dm_ack");
        clr();

        // Timeout into sticky error
        is_St_DM = 1;
        for (int i = 0; i < 13; i++)
            cyc("tmo_wait");
        chk("tmo_no_err_yet", 64'(last_obs[0]), 64'd0);
        cyc("tmo_err");
        chk("tmo_err_bits", {55'd0, last_obs}, 64'h0F3);
        clr();
        cyc("err_sticky");
        chk("err_sticky_bits", {55'd0, last_obs}, 64'h0F3);
        do_reset();
        cyc("post_err");
        chk("post_err_zero", {55'd0, last_obs}, 64'd0);

        // Performance counter scenario
        do_reset();
        is_Ld_ALU = 1; rd_ALU = 3; use_rs1_OF = 1; rs1_OF = 3;
        cyc("perf_lu");
        clr();
        is_Ld_DM = 1;
        for (int i = 0; i < 4; i++) begin
            dm_ack = (i == 3);
            cyc("perf_dm");
        end
        clr();
        branch_taken_ALU = 1;
        cyc("perf_br1");
        cyc("perf_br2");
        clr();
        cyc("perf_end");
`ifdef PERF_CNT_EN
        chk("perf_counts", {perf_stall_cnt, perf_flush_cnt},
            {32'd4, 32'd2});
`else
        chk("perf_counts", {perf_stall_cnt, perf_flush_cnt}, 64'd0);
`endif

        // Constrained random: memory ops held until their ack
        busy = 0; dly = 0;
        for (int i = 0; i < 400; i++) begin
            is_Ld_ALU = 1'($urandom_range(0, 1));
            rd_ALU = 5'($urandom_range(0, 3));
            rs1_OF = 5'($urandom_range(0, 3));
            rs2_OF = 5'($urandom_range(0, 3));
            use_rs1_OF = 1'($urandom_range(0, 1));
            use_rs2_OF = 1'($urandom_range(0, 1));
            branch_taken_ALU = ($urandom_range(0, 3) == 0);
            if (!busy && $urandom_range(0, 2) == 0) begin
                busy = 1;
                dly = $urandom_range(0, 4);
                is_Ld_DM = 1'($urandom_range(0, 1));
                is_St_DM = ~is_Ld_DM;
            end
            if (busy) begin
                dm_ack = (dly == 0);
            end else begin
                is_Ld_DM = 0; is_St_DM = 0;
                dm_ack = ($urandom_range(0, 7) == 0);
            end
            cyc("rand");
            if (busy) begin
                if (dly == 0) busy = 0;
                else dly--;
            end
        end
        clr();
        cyc("rand_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
